// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer between PC/instruction SRAM and the dual-entry FIFO
//
// Purpose: owns the fetch PC and keeps at most one request outstanding to the
// instruction memory. Returned instruction pairs are written into the FIFO, and
// the block handles branch/exception redirects. A response whose request was
// issued before a redirect is dropped and never reaches the FIFO.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect_valid/_pc        redirect request and target
//   inst_req/inst_addr        fetch request to instruction memory
//   inst_addr_ok              request accepted
//   inst_data_ok/_ok1/_ok2    response valid, per-word valid flags
//   inst_rdata1/2             response words at inst_addr and inst_addr+4
//   fifo_full/almost_full     FIFO occupancy (0 / <=1 free entries)
//   fifo_rst                  FIFO flush, pulses with redirect_valid
//   fifo_we*/waddr*/wdata*    FIFO write ports; fifo_wexp1 flags address error
//   pc_curr                   registered fetch PC
//
// Optional macro FETCH_PERF_EN: adds perf_fetch_cnt and perf_discard_cnt.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        inst_data_ok1,
  input  logic        inst_data_ok2,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  input  logic        fifo_full,
  input  logic        fifo_almost_full,
  output logic        fifo_rst,
  output logic        fifo_we1,
  output logic        fifo_we2,
  output logic [31:0] fifo_waddr1,
  output logic [31:0] fifo_waddr2,
  output logic [31:0] fifo_wdata1,
  output logic [31:0] fifo_wdata2,
  output logic        fifo_wexp1,
  output logic [31:0] pc_curr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        accept;
  logic        drop;
  logic [31:0] pc_inc;

  assign pc_curr   = pc_q;
  assign inst_addr = pc_q;

  // Advance by the number of words actually delivered; ok2 without ok1 is not usable.
  always_comb begin
    pc_inc = 32'd0;
    if (inst_data_ok1 && inst_data_ok2) pc_inc = 32'd8;
    else if (inst_data_ok1)             pc_inc = 32'd4;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    inst_req    = 1'b0;
    fifo_rst    = redirect_valid;
    fifo_we1    = 1'b0;
    fifo_we2    = 1'b0;
    fifo_waddr1 = pc_q;
    fifo_waddr2 = pc_q + 32'd4;
    fifo_wdata1 = inst_rdata1;
    fifo_wdata2 = inst_rdata2;
    fifo_wexp1  = 1'b0;
    accept      = 1'b0;
    drop        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          // Request is held low this cycle so the address can change safely.
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if ((pc_q[1:0] != 2'b00) && !fifo_full) begin
          // Misaligned PC: emit a single exception entry and stop fetching.
          fifo_we1    = 1'b1;
          fifo_wexp1  = 1'b1;
          fifo_wdata1 = 32'd0;
          state_d     = S_HALT;
        end else begin
          // Two free entries required so any response fits without back-pressure.
          inst_req = ~fifo_full & ~fifo_almost_full;
          if (inst_req && inst_addr_ok) begin
            accept  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = S_REQ;
          if (redirect_valid) begin
            drop = 1'b1;
            pc_d = redirect_pc;
          end else begin
            fifo_we1 = inst_data_ok1;
            fifo_we2 = inst_data_ok1 & inst_data_ok2;
            pc_d     = pc_q + pc_inc;
          end
        end else if (redirect_valid) begin
          // Response still in flight: remember target, swallow the stale data.
          pend_d  = redirect_pc;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (redirect_valid) pend_d = redirect_pc;
        if (inst_data_ok) begin
          drop    = 1'b1;
          pc_d    = redirect_valid ? redirect_pc : pend_q;
          state_d = S_REQ;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end
    endcase

    if (rst) begin
      inst_req    = 1'b0;
      fifo_rst    = 1'b0;
      fifo_we1    = 1'b0;
      fifo_we2    = 1'b0;
      fifo_waddr1 = 32'd0;
      fifo_waddr2 = 32'd0;
      fifo_wdata1 = 32'd0;
      fifo_wdata2 = 32'd0;
      fifo_wexp1  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt   <= 32'd0;
      perf_discard_cnt <= 32'd0;
    end else begin
      if (accept) perf_fetch_cnt   <= perf_fetch_cnt + 32'd1;
      if (drop)   perf_discard_cnt <= perf_discard_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        inst_data_ok1;
  logic        inst_data_ok2;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;
  logic        fifo_full;
  logic        fifo_almost_full;
  logic        fifo_rst;
  logic        fifo_we1;
  logic        fifo_we2;
  logic [31:0] fifo_waddr1;
  logic [31:0] fifo_waddr2;
  logic [31:0] fifo_wdata1;
  logic [31:0] fifo_wdata2;
  logic        fifo_wexp1;
  logic [31:0] pc_curr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_data_ok1    (inst_data_ok1),
    .inst_data_ok2    (inst_data_ok2),
    .inst_rdata1      (inst_rdata1),
    .inst_rdata2      (inst_rdata2),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_rst         (fifo_rst),
    .fifo_we1         (fifo_we1),
    .fifo_we2         (fifo_we2),
    .fifo_waddr1      (fifo_waddr1),
    .fifo_waddr2      (fifo_waddr2),
    .fifo_wdata1      (fifo_wdata1),
    .fifo_wdata2      (fifo_wdata2),
    .fifo_wexp1       (fifo_wexp1),
    .pc_curr          (pc_curr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_discard_cnt (perf_discard_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    @(negedge clk);
    redirect_valid   = 1'b0;
    inst_addr_ok     = 1'b0;
    inst_data_ok     = 1'b0;
    inst_data_ok1    = 1'b0;
    inst_data_ok2    = 1'b0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
  endtask

  task automatic resp(input logic ok1, input logic ok2, input logic [31:0] d1, input logic [31:0] d2);
    inst_data_ok  = 1'b1;
    inst_data_ok1 = ok1;
    inst_data_ok2 = ok2;
    inst_rdata1   = d1;
    inst_rdata2   = d2;
  endtask

  task automatic redir(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    rst = 1'b1;
    redirect_pc = 32'd0;
    inst_rdata1 = 32'd0;
    inst_rdata2 = 32'd0;
    step();
    // Noisy inputs during reset must not leak to outputs.
    step(); redir(32'h1234_5678); resp(1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF); #1;
    chk("rst_pc", pc_curr, 32'hBFC0_0000);
    chk("rst_req", inst_req, 1'b0);
    chk("rst_fifo_rst", fifo_rst, 1'b0);
    chk("rst_we1", fifo_we1, 1'b0);

    step(); rst = 1'b0; inst_addr_ok = 1'b1; #1;
    chk("c1_req", inst_req, 1'b1);
    chk("c1_addr", inst_addr, 32'hBFC0_0000);
    step(); #1;
    chk("c2_wait_req", inst_req, 1'b0);
    step(); resp(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222); #1;
    chk("c3_we1", fifo_we1, 1'b1);
    chk("c3_we2", fifo_we2, 1'b1);
    chk("c3_waddr1", fifo_waddr1, 32'hBFC0_0000);
    chk("c3_waddr2", fifo_waddr2, 32'hBFC0_0004);
    chk("c3_wdata1", fifo_wdata1, 32'h1111_1111);
    chk("c3_wdata2", fifo_wdata2, 32'h2222_2222);
    step(); inst_addr_ok = 1'b1; #1;
    chk("c4_pc", pc_curr, 32'hBFC0_0008);
    chk("c4_req", inst_req, 1'b1);

    step(); resp(1'b1, 1'b0, 32'h4444_4444, 32'h5555_5555); #1;
    chk("c5_we1", fifo_we1, 1'b1);
    chk("c5_we2", fifo_we2, 1'b0);
    step(); inst_addr_ok = 1'b1; #1;
    chk("c6_addr", inst_addr, 32'hBFC0_000C);
    step(); resp(1'b1, 1'b0, 32'h3333_3333, 32'h6666_6666); #1;
    chk("c7_we1", fifo_we1, 1'b1);
    chk("c7_we2", fifo_we2, 1'b0);
    chk("c7_wdata1", fifo_wdata1, 32'h3333_3333);
    chk("c7_waddr1", fifo_waddr1, 32'hBFC0_000C);
    step(); inst_addr_ok = 1'b1; #1;
    chk("c8_addr", inst_addr, 32'hBFC0_0010);
    step(); resp(1'b0, 1'b1, 32'h7777_7777, 32'h8888_8888); #1;
    chk("c9_we1", fifo_we1, 1'b0);
    chk("c9_we2", fifo_we2, 1'b0);
    step(); inst_addr_ok = 1'b1; #1;
    chk("c10_refetch_addr", inst_addr, 32'hBFC0_0010);
    chk("c10_req", inst_req, 1'b1);

    // Redirect while waiting; the late response must be dropped.
    step(); redir(32'h8000_1000); #1;
    chk("c11_fifo_rst", fifo_rst, 1'b1);
    chk("c11_we1", fifo_we1, 1'b0);
    step(); #1;
    chk("c12_fifo_rst", fifo_rst, 1'b0);
    chk("c12_req", inst_req, 1'b0);
    step(); resp(1'b1, 1'b1, 32'h9999_9999, 32'hAAAA_AAAA); #1;
    chk("c13_we1", fifo_we1, 1'b0);
    chk("c13_we2", fifo_we2, 1'b0);
    step(); inst_addr_ok = 1'b1; #1;
    chk("c14_addr", inst_addr, 32'h8000_1000);
    chk("c14_req", inst_req, 1'b1);
`ifdef FETCH_PERF_EN
    chk("c14_perf_discard", perf_discard_cnt, 32'd1);
`endif

    // Redirect coincident with data_ok.
    step(); resp(1'b1, 1'b1, 32'hBBBB_BBBB, 32'hCCCC_CCCC); redir(32'h8000_2000); #1;
    chk("c15_we1", fifo_we1, 1'b0);
    chk("c15_we2", fifo_we2, 1'b0);
    chk("c15_fifo_rst", fifo_rst, 1'b1);
    step(); #1;
    chk("c16_pc", pc_curr, 32'h8000_2000);
    chk("c16_req", inst_req, 1'b1);

    // Almost-full must gate requests, even with addr_ok asserted.
    for (int i = 0; i < 5; i++) begin
      step(); fifo_almost_full = 1'b1; inst_addr_ok = 1'b1; #1;
      chk("afull_req", inst_req, 1'b0);
    end
    step(); #1;
    chk("afull_drop_req", inst_req, 1'b1);
    chk("afull_drop_addr", inst_addr, 32'h8000_2000);
    step(); fifo_full = 1'b1; fifo_almost_full = 1'b1; inst_addr_ok = 1'b1; #1;
    chk("full_req", inst_req, 1'b0);

    // Misaligned redirect target produces one exception entry then halts.
    step(); redir(32'h8000_0002); #1;
    chk("mis_redir_rst", fifo_rst, 1'b1);
    chk("mis_redir_req", inst_req, 1'b0);
    step(); #1;
    chk("mis_we1", fifo_we1, 1'b1);
    chk("mis_wexp1", fifo_wexp1, 1'b1);
    chk("mis_waddr1", fifo_waddr1, 32'h8000_0002);
    chk("mis_wdata1", fifo_wdata1, 32'd0);
    chk("mis_we2", fifo_we2, 1'b0);
    chk("mis_req", inst_req, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(); inst_addr_ok = 1'b1; resp(1'b1, 1'b1, 32'h1, 32'h2); #1;
      chk("halt_req", inst_req, 1'b0);
      chk("halt_we1", fifo_we1, 1'b0);
    end
    step(); redir(32'h8000_0000); #1;
    chk("halt_exit_rst", fifo_rst, 1'b1);
    step(); inst_addr_ok = 1'b1; #1;
    chk("resume_req", inst_req, 1'b1);
    chk("resume_addr", inst_addr, 32'h8000_0000);

    // PC wrap: top-of-memory pair.
    step(); resp(1'b1, 1'b1, 32'h1, 32'h2); redir(32'hFFFF_FFFC); #1;
    chk("wrap_drop_we1", fifo_we1, 1'b0);
    step(); inst_addr_ok = 1'b1; #1;
    chk("wrap_addr", inst_addr, 32'hFFFF_FFFC);
    step(); resp(1'b1, 1'b1, 32'hCAFE_0001, 32'hCAFE_0002); #1;
    chk("wrap_waddr1", fifo_waddr1, 32'hFFFF_FFFC);
    chk("wrap_waddr2", fifo_waddr2, 32'h0000_0000);
    chk("wrap_we2", fifo_we2, 1'b1);
    step(); inst_addr_ok = 1'b1; #1;
    chk("wrap_pc", pc_curr, 32'h0000_0004);

    // Redirect in WAIT, then a second redirect together with the response.
    step(); redir(32'h9000_0000); #1;
    step(); redir(32'hA000_0000); resp(1'b1, 1'b1, 32'h3, 32'h4); #1;
    chk("disc2_we1", fifo_we1, 1'b0);
    chk("disc2_fifo_rst", fifo_rst, 1'b1);
    step(); #1;
    chk("disc2_pc", pc_curr, 32'hA000_0000);
    chk("disc2_req", inst_req, 1'b1);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, 32'd9);
    chk("perf_discard", perf_discard_cnt, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC/instruction-SRAM interface and the dual-entry instruction FIFO of the dual-issue datapath. Owns the fetch PC, issues one request at a time to the instruction memory, writes returned instruction pairs into the FIFO, and handles redirects from branches and exceptions. Responses that were requested before a redirect arrives are dropped; they never reach the FIFO.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- redirect_valid  in  1  branch/exception redirect, sampled at posedge
- redirect_pc  in  32  redirect target
- inst_req  out  1  fetch request valid
- inst_addr  out  32  fetch address (= pc_curr)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response valid this cycle
- inst_data_ok1  in  1  word at inst_addr valid in response
- inst_data_ok2  in  1  word at inst_addr+4 valid in response
- inst_rdata1  in  32  word at inst_addr
- inst_rdata2  in  32  word at inst_addr+4
- fifo_full  in  1  FIFO has 0 free entries
- fifo_almost_full  in  1  FIFO has ≤1 free entry
- fifo_rst  out  1  FIFO flush
- fifo_we1  out  1  write enable, entry 1
- fifo_we2  out  1  write enable, entry 2
- fifo_waddr1  out  32  PC of entry 1
- fifo_waddr2  out  32  PC of entry 2
- fifo_wdata1  out  32  instruction, entry 1
- fifo_wdata2  out  32  instruction, entry 2
- fifo_wexp1  out  1  address-error flag, entry 1
- pc_curr  out  32  registered fetch PC

## Operation
- States: REQ, WAIT, DISCARD, HALT. Registers: state, pc_curr, pending_pc (32).
- REQ:
  - pc_curr[1:0]!=0 and ~fifo_full: inst_req=0. Write entry 1 with fifo_wexp1=1, fifo_waddr1=pc_curr and fifo_wdata1=0. Go to HALT.
  - Otherwise inst_req = ~fifo_full & ~fifo_almost_full & ~redirect_valid.
  - inst_req & inst_addr_ok: go to WAIT.
- WAIT: inst_req=0. When inst_data_ok:
  - fifo_we1=ok1 and fifo_we2=ok1&ok2. waddr1=pc_curr, waddr2=pc_curr+4. wdata is the rdata passed through.
  - pc_curr += 4*(ok1+(ok1&ok2)). A response with ok1=0 refetches the same PC.
  - Go to REQ.
- DISCARD: no FIFO writes. On inst_data_ok, load pc_curr=pending_pc and go to REQ.
- HALT: inst_req=0, no writes. Exits only on redirect.
- Redirect, combinational pulse fifo_rst=redirect_valid:
  - REQ with no acceptance this cycle, or HALT: pc_curr=redirect_pc, go to REQ.
  - REQ with inst_addr_ok high in the same cycle (not possible while inst_req is forced low), or WAIT without data_ok: pending_pc=redirect_pc, go to DISCARD. All FIFO writes are suppressed in that cycle.
  - WAIT with data_ok in the same cycle: drop the data (we=0), pc_curr=redirect_pc, go to REQ.
  - DISCARD: overwrite pending_pc. If data_ok is also high, pc_curr=redirect_pc and go to REQ.
- Flow control: at most one request is ever outstanding, and a request is issued only when the FIFO has ≥2 free entries. This block is the only FIFO writer, so a response can never overflow the FIFO.
- PC arithmetic: 32-bit modulo 2^32. 0xFFFFFFFC+4 wraps to 0.

## Timing
- Reset (rst high at a posedge): pc_curr=RESET_PC, state=REQ, pending_pc=0. While rst is high, all outputs except pc_curr and inst_addr are forced to 0.
- First inst_req appears in the first cycle after rst deasserts.
- FIFO writes and fifo_rst are combinational in the response/redirect cycle. The FIFO captures them at the same edge.
- Minimum request-to-request spacing is 2 cycles: addr_ok, then data_ok at the earliest on the next cycle.
- inst_data_ok in the same cycle as inst_addr_ok is not allowed, and is ignored in REQ.
- inst_addr is stable while inst_req=1 until accepted. A redirect lowers inst_req for that cycle before the address changes.

## Configuration
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch_cnt[31:0], which counts accepted requests.
  - Adds perf_discard_cnt[31:0], which counts responses dropped in DISCARD or on simultaneous redirect.
  - Both counters are reset to 0 by rst and wrap at 2^32.
- FETCH_PERF_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then addr_ok in cycle 1 and data_ok with ok1=ok2=1 in cycle 3 → entries 0xBFC00000/0xBFC00004 written, pc_curr=0xBFC00008, next inst_req in cycle 4.
- Response with ok1=1, ok2=0 at pc 0xBFC0000C → only we1 asserted, pc_curr=0xBFC00010. Response with ok1=0 → no writes, same PC re-requested.
- Redirect to 0x80001000 while in WAIT, data_ok two cycles later → fifo_rst pulses once, response dropped, next inst_addr=0x80001000. perf_discard_cnt=1 when FETCH_PERF_EN is defined.
- Redirect coincident with data_ok → no fifo_we, pc_curr=redirect_pc, REQ on the next cycle.
- fifo_almost_full held high for 5 cycles → inst_req stays 0. It rises in the cycle after fifo_almost_full drops.
- Redirect to 0x80000002 → one entry written with fifo_wexp1=1, waddr1=0x80000002, wdata1=0. HALT with no inst_req until a redirect to 0x80000000 resumes fetch.
